// File: rtl/instr_mem_loadable.sv
// Fetch-stage instruction memory: 1-cycle registered read with stall hold, plus a
// streaming program-load port that rewrites the image without re-elaboration.
module instr_mem_loadable #(
    parameter int              IW        = 9,
    parameter int              AW        = 8,
    parameter int              DEPTH     = 256,
    parameter logic [IW-1:0]   NOP       = '0,
    parameter string           INIT_FILE = "Beeth9MachineCode.txt"
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          fetch_en,
    input  logic [AW-1:0] fetch_addr,
    input  logic          stall,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    output logic          busy,
    output logic          load_err,
    output logic [AW:0]   prog_len
);

    localparam int          MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [IW-1:0] mem [DEPTH];

    logic [AW:0]   wr_ptr_q;
    logic          load_err_q;
    logic [AW:0]   prog_len_q;

    logic          accept;
    logic          in_prog;
    logic [IW-1:0] instr_p1;
    logic          vld_p1;

    // Write pointer stops at DEPTH so an overrun keeps reporting DEPTH words.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] p);
        return (p >= DEPTH_L) ? DEPTH_L : p + (AW+1)'(1);
    endfunction

    function automatic logic [IW-1:0] fetch_word(input logic in_range,
                                                 input logic [IW-1:0] word);
        return in_range ? word : NOP;
    endfunction

    assign accept  = (state_q == ST_LOAD) && load_valid;
    assign in_prog = ({1'b0, fetch_addr} < prog_len_q) && ({1'b0, fetch_addr} < DEPTH_L);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (load_start) state_d = ST_LOAD;
            ST_LOAD: if (load_valid && load_last) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        load_ready = 1'b0;
        if (state_q == ST_LOAD) begin
            busy       = 1'b1;
            load_ready = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            load_err_q <= 1'b0;
            prog_len_q <= DEPTH_L;
        end else if (state_q == ST_RUN) begin
            if (load_start) begin
                wr_ptr_q   <= '0;
                load_err_q <= 1'b0;
            end
        end else if (accept) begin
            wr_ptr_q <= sat_inc(wr_ptr_q);
            if (wr_ptr_q >= DEPTH_L) load_err_q <= 1'b1;
            if (load_last) prog_len_q <= sat_inc(wr_ptr_q);
        end
    end

    // Memory array is deliberately left out of reset; overrun words are dropped.
    always_ff @(posedge CLK) begin
        if (accept && (wr_ptr_q < DEPTH_L)) begin
            mem[wr_ptr_q[MW-1:0]] <= load_data;
        end
    end

    // Stage p1: registered read; stall holds both word and valid.
    always_ff @(posedge CLK) begin
        if (reset) begin
            instr_p1 <= NOP;
            vld_p1   <= 1'b0;
        end else if ((state_q == ST_LOAD) || load_start) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= fetch_en;
            if (fetch_en) instr_p1 <= fetch_word(in_prog, mem[fetch_addr[MW-1:0]]);
        end
    end

    assign instr_out   = instr_p1;
    assign instr_valid = vld_p1;
    assign load_err    = load_err_q;
    assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a DEPTH=256 instance and a DEPTH=4 instance
// share one stimulus stream; the small one exercises load overrun.
module tb_instr_mem_loadable;

    logic       clk;
    logic       reset;
    logic       fetch_en;
    logic [7:0] fetch_addr;
    logic       stall;
    logic       load_start;
    logic       load_valid;
    logic [8:0] load_data;
    logic       load_last;

    logic [8:0] instr_out,  s_instr_out;
    logic       instr_valid, s_instr_valid;
    logic       load_ready, s_load_ready;
    logic       busy, s_busy;
    logic       load_err, s_load_err;
    logic [8:0] prog_len, s_prog_len;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] img [8] = '{9'h101, 9'h0A5, 9'h15A, 9'h0FF, 9'h011, 9'h1C3, 9'h07E, 9'h1F0};
    logic [8:0] ovr [6] = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};

    instr_mem_loadable #(.IW(9), .AW(8), .DEPTH(256), .NOP(9'h000), .INIT_FILE("")) u_dut (
        .CLK(clk), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr), .stall(stall),
        .instr_out(instr_out), .instr_valid(instr_valid), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .busy(busy), .load_err(load_err), .prog_len(prog_len)
    );

    instr_mem_loadable #(.IW(9), .AW(8), .DEPTH(4), .NOP(9'h000), .INIT_FILE("")) u_small (
        .CLK(clk), .reset(reset), .fetch_en(fetch_en), .fetch_addr(fetch_addr), .stall(stall),
        .instr_out(s_instr_out), .instr_valid(s_instr_valid), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(s_load_ready), .busy(s_busy), .load_err(s_load_err), .prog_len(s_prog_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [8:0] w, input logic last);
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a);
        fetch_en   = 1'b1;
        fetch_addr = a;
        tick();
    endtask

    task automatic start_load;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; fetch_addr = '0; stall = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_instr", 32'(instr_out), 'h000);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_ready", 32'(load_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(load_err), 0);
        check("rst_len", 32'(prog_len), 256);
        check("rst_len_small", 32'(s_prog_len), 4);

        // Program image via the load port (no preload file in this bench)
        start_load();
        check("img_busy", 32'(busy), 1);
        check("img_ready", 32'(load_ready), 1);
        for (int i = 0; i < 8; i++) send_word(img[i], i == 7);
        check("img_busy_done", 32'(busy), 0);
        check("img_len", 32'(prog_len), 8);

        // T1: back-to-back fetch
        for (int i = 0; i < 4; i++) begin
            fetch(8'(i));
            check("t1_instr", 32'(instr_out), 32'(img[i]));
            check("t1_valid", 32'(instr_valid), 1);
        end
        fetch_en = 1'b0;
        tick();
        check("idle_valid", 32'(instr_valid), 0);
        check("idle_hold", 32'(instr_out), 'h0FF);

        // T2: stall hold
        fetch(8'd5);
        check("t2_first", 32'(instr_out), 'h1C3);
        stall = 1'b1;
        fetch_addr = 8'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold", 32'(instr_out), 'h1C3);
            check("t2_hold_vld", 32'(instr_valid), 1);
        end
        stall = 1'b0;
        tick();
        check("t2_release", 32'(instr_out), 'h07E);
        fetch(8'd7);
        check("last_in_prog", 32'(instr_out), 'h1F0);
        fetch(8'd8);
        check("past_prog", 32'(instr_out), 'h000);
        check("past_prog_vld", 32'(instr_valid), 1);
        fetch_en = 1'b0;

        // T6: reset in the middle of a load
        start_load();
        send_word(9'h155, 1'b0);
        send_word(9'h0AA, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy", 32'(busy), 0);
        check("t6_ready", 32'(load_ready), 0);
        check("t6_len", 32'(prog_len), 256);
        check("t6_instr", 32'(instr_out), 'h000);
        fetch(8'd0);
        check("t6_w0", 32'(instr_out), 'h155);
        fetch(8'd1);
        check("t6_w1", 32'(instr_out), 'h0AA);
        fetch(8'd2);
        check("t6_old", 32'(instr_out), 'h15A);

        // T3 + T5: load with a valid gap while fetch_en stays high
        fetch_en = 1'b1;
        fetch_addr = 8'd0;
        start_load();
        check("t5_start_vld", 32'(instr_valid), 0);
        check("t3_busy", 32'(busy), 1);
        fetch_addr = 8'd2;
        send_word(9'h1A1, 1'b0);
        check("t5_vld_w0", 32'(instr_valid), 0);
        tick();
        check("t5_vld_gap", 32'(instr_valid), 0);
        check("t3_busy_gap", 32'(busy), 1);
        send_word(9'h0F2, 1'b0);
        check("t5_vld_w1", 32'(instr_valid), 0);
        send_word(9'h133, 1'b1);
        check("t3_busy_done", 32'(busy), 0);
        check("t3_ready_done", 32'(load_ready), 0);
        check("t3_len", 32'(prog_len), 3);
        check("t5_vld_last", 32'(instr_valid), 0);
        fetch(8'd2);
        check("t3_w2", 32'(instr_out), 'h133);
        check("t3_w2_vld", 32'(instr_valid), 1);
        fetch(8'd0);
        check("t5_w0", 32'(instr_out), 'h1A1);
        fetch(8'd1);
        check("t5_w1", 32'(instr_out), 'h0F2);
        fetch(8'd3);
        check("t3_nop", 32'(instr_out), 'h000);
        check("t3_nop_vld", 32'(instr_valid), 1);
        fetch_en = 1'b0;

        // T4: overrun on the DEPTH=4 instance
        check("t4_pre_len", 32'(s_prog_len), 3);
        start_load();
        check("t4_busy", 32'(s_busy), 1);
        for (int i = 0; i < 4; i++) send_word(ovr[i], 1'b0);
        check("t4_err_at_depth", 32'(s_load_err), 0);
        send_word(ovr[4], 1'b0);
        check("t4_err_set", 32'(s_load_err), 1);
        check("t4_still_busy", 32'(s_busy), 1);
        send_word(ovr[5], 1'b1);
        check("t4_exit", 32'(s_busy), 0);
        check("t4_len", 32'(s_prog_len), 4);
        check("t4_err_sticky", 32'(s_load_err), 1);
        fetch(8'd3);
        check("t4_w3", 32'(s_instr_out), 'h044);
        fetch(8'd0);
        check("t4_w0", 32'(s_instr_out), 'h011);
        fetch(8'd4);
        check("t4_beyond", 32'(s_instr_out), 'h000);
        fetch_en = 1'b0;
        start_load();
        check("t4_err_clear", 32'(s_load_err), 0);
        send_word(9'h077, 1'b1);
        check("t4_len_one", 32'(s_prog_len), 1);
        fetch(8'd0);
        check("t4_new_w0", 32'(s_instr_out), 'h077);
        fetch(8'd1);
        check("t4_new_nop", 32'(s_instr_out), 'h000);
        fetch_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
